// File: rtl/dds_dual_controller_pkg.sv
// rtl/dds_dual_controller_pkg.sv - shared constants and types for the dual DDS controller
package dds_pkg;
  localparam int ACC_W  = 32;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 14;

  localparam logic [2:0] REG_FTW        = 3'd0;
  localparam logic [2:0] REG_PHASE_OFF  = 3'd1;
  localparam logic [2:0] REG_SWEEP_STEP = 3'd2;
  localparam logic [2:0] REG_SWEEP_END  = 3'd3;
  localparam logic [2:0] REG_SWEEP_DIV  = 3'd4;
  localparam logic [2:0] REG_CTRL       = 3'd5;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_SWEEP_EN = 1;
  localparam int CTRL_INVERT_B = 2;

  localparam logic [DATA_W-1:0] MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SWEEP, ST_HOLD} state_t;
endpackage

// File: rtl/dds_dual_controller_if.sv
// rtl/dds_dual_controller_if.sv - valid/ready configuration write port
interface dds_dual_controller_if;
  import dds_pkg::*;

  logic             valid;
  logic             ready;
  logic [2:0]       addr;
  logic [ACC_W-1:0] data;

  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/dds_sweep_unit.sv
// rtl/dds_sweep_unit.sv - sweep divider, signed tuning-word step and end clamp
module dds_sweep_unit
  import dds_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             commit,
  input  logic [15:0]      div,
  input  logic [ACC_W-1:0] ftw,
  input  logic [ACC_W-1:0] step,
  input  logic [ACC_W-1:0] end_ftw,
  output logic             update,
  output logic             hit_end,
  output logic [ACC_W-1:0] ftw_next
);
  logic [15:0]             cnt;
  logic signed [ACC_W+1:0] sum;
  logic signed [ACC_W+1:0] end_ext;

  // Two guard bits keep an unsigned FTW plus a signed step free of overflow
  assign sum     = $signed({2'b00, ftw}) + $signed({{2{step[ACC_W-1]}}, step});
  assign end_ext = $signed({2'b00, end_ftw});
  assign update  = active && (cnt == div);

  // A zero step ends the sweep on its first update; otherwise clamp in the step direction
  always_comb begin
    hit_end  = 1'b0;
    ftw_next = sum[ACC_W-1:0];
    if (step == '0) begin
      hit_end  = 1'b1;
      ftw_next = ftw;
    end else if (!step[ACC_W-1]) begin
      hit_end = (sum >= end_ext);
    end else begin
      hit_end = (sum <= end_ext);
    end
    if (hit_end && step != '0) ftw_next = end_ftw;
  end

  // Divider runs only while sweeping and restarts on every commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (commit || !active)  cnt <= '0;
    else if (cnt == div)         cnt <= '0;
    else                         cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/dds_dual_controller.sv
// rtl/dds_dual_controller.sv - dual-channel DDS sequencer: accumulator, ROM addressing, DAC registers
module dds_dual_controller
  import dds_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  dds_dual_controller_if.slave  cfg,
  output logic [ADDR_W-1:0]     rom_addr_a,
  output logic [ADDR_W-1:0]     rom_addr_b,
  input  logic [DATA_W-1:0]     rom_q_a,
  input  logic [DATA_W-1:0]     rom_q_b,
  output logic [DATA_W-1:0]     dac_a,
  output logic [DATA_W-1:0]     dac_b,
  output logic                  running,
  output logic                  sweep_done
);
  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sh_ftw, sh_off, sh_step, sh_end;
  logic [15:0]      sh_div;
  logic [ACC_W-1:0] ftw, phase_off, step, end_ftw;
  logic [15:0]      sweep_div;
  logic             invert_b;
  logic [1:0]       vld;
  logic             wr, commit;
  logic             sw_update, sw_hit;
  logic [ACC_W-1:0] sw_ftw;

  assign wr     = cfg.valid && cfg.ready;
  assign commit = wr && (cfg.addr == REG_CTRL);

  dds_sweep_unit u_sweep (
    .clk      (clk),
    .rst      (rst),
    .active   (state == ST_SWEEP),
    .commit   (commit),
    .div      (sweep_div),
    .ftw      (ftw),
    .step     (step),
    .end_ftw  (end_ftw),
    .update   (sw_update),
    .hit_end  (sw_hit),
    .ftw_next (sw_ftw)
  );

  // Shadow registers capture writes to 0-4; addresses 6-7 are accepted and dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_ftw  <= '0;
      sh_off  <= '0;
      sh_step <= '0;
      sh_end  <= '0;
      sh_div  <= '0;
    end else if (wr) begin
      case (cfg.addr)
        REG_FTW:        sh_ftw  <= cfg.data;
        REG_PHASE_OFF:  sh_off  <= cfg.data;
        REG_SWEEP_STEP: sh_step <= cfg.data;
        REG_SWEEP_END:  sh_end  <= cfg.data;
        REG_SWEEP_DIV:  sh_div  <= cfg.data[15:0];
        default: ;
      endcase
    end
  end

  // Mode FSM: a commit loads every active register at once; sweep updates are dropped on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      ftw        <= '0;
      phase_off  <= '0;
      step       <= '0;
      end_ftw    <= '0;
      sweep_div  <= '0;
      invert_b   <= 1'b0;
      running    <= 1'b0;
      sweep_done <= 1'b0;
      cfg.ready  <= 1'b1;
    end else begin
      cfg.ready  <= !commit;
      sweep_done <= 1'b0;
      if (commit) begin
        ftw       <= sh_ftw;
        phase_off <= sh_off;
        step      <= sh_step;
        end_ftw   <= sh_end;
        sweep_div <= sh_div;
        invert_b  <= cfg.data[CTRL_INVERT_B];
        acc       <= '0;
        if (!cfg.data[CTRL_RUN]) begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end else if (cfg.data[CTRL_SWEEP_EN]) begin
          state   <= ST_SWEEP;
          running <= 1'b1;
        end else begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
      end else begin
        if (state != ST_IDLE) acc <= acc + ftw;
        if (sw_update) begin
          ftw <= sw_ftw;
          if (sw_hit) begin
            state      <= ST_HOLD;
            sweep_done <= 1'b1;
          end
        end
      end
    end
  end

  // Address and DAC pipeline; vld tracks which stages hold data from the current mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_a <= '0;
      rom_addr_b <= '0;
      vld        <= 2'b00;
      dac_a      <= MIDSCALE;
      dac_b      <= MIDSCALE;
    end else begin
      rom_addr_a <= acc[ACC_W-1 -: ADDR_W];
      rom_addr_b <= ADDR_W'((acc + phase_off) >> (ACC_W - ADDR_W));
      vld        <= commit ? 2'b00 : {vld[0], state != ST_IDLE};
      dac_a      <= vld[1] ? rom_q_a : MIDSCALE;
      dac_b      <= vld[1] ? (invert_b ? ~rom_q_b : rom_q_b) : MIDSCALE;
    end
  end
endmodule
